// File: rtl/credit_to_time_pkg.sv
// Shared definitions for the cents-to-seconds converter: hour band bounds and FSM encoding.
package credit_to_time_pkg;

    localparam int HOUR_PEAK_START = 8;
    localparam int HOUR_PEAK_END   = 18;
    localparam int HOURS_PER_DAY   = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_peak(input logic [4:0] hour);
        return (hour >= 5'(HOUR_PEAK_START)) && (hour < 5'(HOUR_PEAK_END));
    endfunction

endpackage

// File: rtl/credit_to_time_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; done_o pulses one cycle after the last bit.
module seq_divider #(
    parameter int NUM_W = 20,
    parameter int DEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DEN_W-1:0] den_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [NUM_W-1:0] quo_o,
    output logic [DEN_W-1:0] rem_o
);

    localparam int CNT_W = $clog2(NUM_W);

    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             ge;

    // quo_q starts as the dividend and is shifted out while quotient bits shift in
    always_comb begin
        trial  = {rem_q, quo_q[NUM_W-1]};
        diff   = trial - {1'b0, den_q};
        ge     = trial >= {1'b0, den_q};
        quo_d  = quo_q;
        rem_d  = rem_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            quo_d  = num_i;
            rem_d  = '0;
            den_d  = den_i;
            cnt_d  = CNT_W'(NUM_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            quo_d = {quo_q[NUM_W-2:0], ge};
            rem_d = ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/credit_to_time.sv
// Converts paid cents into parking seconds at the hour-band rate, with valid/ready on both sides.
// Optional build macro REMAINDER_CARRY_EN carries the division remainder into the next request.
//
// state   | meaning
// IDLE    | ready for a request
// CALC    | divider running
// DONE    | result presented until the consumer takes it
module credit_to_time
    import credit_to_time_pkg::*;
#(
    parameter int         CENTS_W      = 14,
    parameter int         SEC_W        = 12,
    parameter logic [3:0] OFFPEAK_RATE = 4'd1,
    parameter logic [3:0] PEAK_RATE    = 4'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         sw,
    input  logic [CENTS_W-1:0] cents_in,
    input  logic               req_valid,
    output logic               req_ready,
    output logic [SEC_W-1:0]   sec_out,
    output logic               sat,
    output logic               err,
    output logic               resp_valid,
    input  logic               resp_ready
);

    localparam int NUM_W = CENTS_W + 6;

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic             resp_valid_q, resp_valid_d;

    logic [4:0]       hour;
    logic [3:0]       rate;
    logic [NUM_W-1:0] num;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_quo;
    logic [3:0]       div_rem;
    logic             div_ovf;
    logic             unused_bits;

    assign hour    = sw[4:0];
    assign rate    = is_peak(hour) ? PEAK_RATE : OFFPEAK_RATE;
    assign div_ovf = |div_quo[NUM_W-1:SEC_W];

`ifdef REMAINDER_CARRY_EN
    logic [3:0] carry_q, carry_d;
    assign num = NUM_W'(cents_in) * NUM_W'(60) + NUM_W'(carry_q);
    assign unused_bits = ^{sw[7:5], div_busy};
`else
    assign num = NUM_W'(cents_in) * NUM_W'(60);
    assign unused_bits = ^{sw[7:5], div_busy, div_rem};
`endif

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(4)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .num_i   (num),
        .den_i   (rate),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .quo_o   (div_quo),
        .rem_o   (div_rem)
    );

    always_comb begin
        state_d      = state_q;
        sec_d        = sec_q;
        sat_d        = sat_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        div_start    = 1'b0;
`ifdef REMAINDER_CARRY_EN
        carry_d      = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (hour >= 5'(HOURS_PER_DAY)) begin
                        // resp_valid follows one cycle later from DONE
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        sec_d   = '0;
                        sat_d   = 1'b0;
`ifdef REMAINDER_CARRY_EN
                        carry_d = '0;
`endif
                    end else begin
                        state_d   = ST_CALC;
                        div_start = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (div_done) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    err_d        = 1'b0;
                    sat_d        = div_ovf;
                    sec_d        = div_ovf ? '1 : div_quo[SEC_W-1:0];
`ifdef REMAINDER_CARRY_EN
                    carry_d      = div_rem;
`endif
                end
            end
            ST_DONE: begin
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sec_q        <= '0;
            sat_q        <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef REMAINDER_CARRY_EN
            carry_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sec_q        <= sec_d;
            sat_q        <= sat_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
`ifdef REMAINDER_CARRY_EN
            carry_q      <= carry_d;
`endif
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign sec_out    = sec_q;
    assign sat        = sat_q;
    assign err        = err_q;

endmodule

// File: tb/tb_credit_to_time.sv
// Directed bench for credit_to_time: latency, rate bands, clamping, error path, stall and reset abort.
module tb_credit_to_time;

`ifdef REMAINDER_CARRY_EN
    localparam logic [3:0] PEAK   = 4'd7;
    localparam int         EXP_P7 = 60;
`else
    localparam logic [3:0] PEAK   = 4'd2;
    localparam int         EXP_P7 = 210;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic [13:0] cents_in;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] sec_out;
    logic        sat;
    logic        err;
    logic        resp_valid;
    logic        resp_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    credit_to_time #(
        .CENTS_W(14),
        .SEC_W(12),
        .OFFPEAK_RATE(4'd1),
        .PEAK_RATE(PEAK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .cents_in   (cents_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .sec_out    (sec_out),
        .sat        (sat),
        .err        (err),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".vld_drop"}, 32'(resp_valid), 0);
        chk({tag, ".rdy_back"}, 32'(req_ready), 1);
    endtask

    task automatic run_req(input string tag, input logic [4:0] hour, input logic [13:0] cents,
                           input int exp_lat, input int exp_sec, input int exp_sat,
                           input int exp_err, input bit do_ack);
        int cyc;
        @(negedge clk);
        sw        = {3'b101, hour};
        cents_in  = cents;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sw        = ~sw;
        cents_in  = 14'h3FFF;
        cyc = 0;
        while (!resp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".lat"}, cyc, exp_lat);
        chk({tag, ".sec"}, 32'(sec_out), exp_sec);
        chk({tag, ".sat"}, 32'(sat), exp_sat);
        chk({tag, ".err"}, 32'(err), exp_err);
        chk({tag, ".rdy_busy"}, 32'(req_ready), 0);
        if (do_ack) ack(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  seen;
        rst        = 1'b1;
        sw         = 8'h00;
        cents_in   = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 1);
        chk("rst.resp_valid", 32'(resp_valid), 0);
        chk("rst.sec", 32'(sec_out), 0);
        chk("rst.sat", 32'(sat), 0);
        chk("rst.err", 32'(err), 0);
        rst = 1'b0;

        run_req("t1_off", 5'd3, 14'd10, 21, 600, 0, 0, 1'b1);
        run_req("t2_peak", 5'd9, 14'd7, 21, EXP_P7, 0, 0, 1'b1);
        run_req("t3_clamp", 5'd2, 14'd100, 21, 4095, 1, 0, 1'b1);
        run_req("t4_err", 5'd25, 14'd5, 1, 0, 0, 1, 1'b1);
        run_req("zero", 5'd12, 14'd0, 21, 0, 0, 0, 1'b1);
        run_req("fit_max", 5'd0, 14'd68, 21, 4080, 0, 0, 1'b1);
        run_req("just_over", 5'd23, 14'd69, 21, 4095, 1, 0, 1'b1);
        run_req("h8_peak", 5'd8, 14'd7, 21, EXP_P7, 0, 0, 1'b1);
        run_req("h17_peak", 5'd17, 14'd7, 21, EXP_P7, 0, 0, 1'b1);
        run_req("h7_off", 5'd7, 14'd7, 21, 420, 0, 0, 1'b1);
        run_req("h18_off", 5'd18, 14'd1, 21, 60, 0, 0, 1'b1);
        run_req("h24_err", 5'd24, 14'd1, 1, 0, 0, 1, 1'b1);
        run_req("after_err", 5'd3, 14'd2, 21, 120, 0, 0, 1'b1);

        // held result under back-pressure, with new requests offered meanwhile
        run_req("t5_stall", 5'd3, 14'd10, 21, 600, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            sw        = 8'(i + 1);
            cents_in  = 14'(i * 37 + 5);
            @(posedge clk);
            #1;
            chk("t5.sec", 32'(sec_out), 600);
            chk("t5.sat", 32'(sat), 0);
            chk("t5.err", 32'(err), 0);
            chk("t5.vld", 32'(resp_valid), 1);
            chk("t5.rdy", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        ack("t5");

        // reset part way through the divide
        @(negedge clk);
        sw        = 8'd9;
        cents_in  = 14'd7;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6.rdy", 32'(req_ready), 1);
        chk("t6.vld", 32'(resp_valid), 0);
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1;
        end
        chk("t6.no_resp", seen, 0);
        run_req("t6_next", 5'd9, 14'd7, 21, EXP_P7, 0, 0, 1'b1);

`ifdef REMAINDER_CARRY_EN
        run_req("carry1", 5'd9, 14'd1, 21, 8, 0, 0, 1'b1);
        run_req("carry2", 5'd9, 14'd1, 21, 9, 0, 0, 1'b1);
        run_req("carry_err", 5'd30, 14'd1, 1, 0, 0, 1, 1'b1);
        run_req("carry_clr", 5'd9, 14'd1, 21, 8, 0, 0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
